// File: rtl/ladybird_axi_burst_addr_gen.sv
// Purpose: per-beat AXI4 address generator (FIXED/INCR/WRAP) with command legality checking.
// Latency: first beat descriptor one cycle after command acceptance; errors pulse one cycle after.
// Backpressure: beat outputs hold while beat_ready=0; cmd_ready only in IDLE or on the last-beat handshake.
module ladybird_axi_burst_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LANE_W = $clog2(DATA_W/8)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [ADDR_W-1:0] beat_addr,
  output logic [LANE_W-1:0] beat_lane,
  output logic [7:0]        beat_idx,
  output logic              beat_last,
  output logic              err_valid,
  output logic [1:0]        err_code
);

  typedef enum logic {S_IDLE, S_BURST} state_e;

  localparam logic [1:0] B_FIXED = 2'd0;
  localparam logic [1:0] B_INCR  = 2'd1;
  localparam logic [1:0] B_WRAP  = 2'd2;
  localparam logic [1:0] B_RSVD  = 2'd3;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, wrap_low_q, wrap_end_q;
  logic [7:0]        idx_q, len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              err_valid_q;
  logic [1:0]        err_code_q;

  logic              cmd_acc, beat_acc;
  logic              cmd_err;
  logic [1:0]        cmd_err_code;
  logic [ADDR_W-1:0] cmd_mask, cmd_total, cmd_last_byte, cmd_wrap_low;
  logic [ADDR_W-1:0] step, addr_nxt, wrap_inc;

  // Decode the incoming command: wrap window and first-matching error cause
  always_comb begin
    cmd_mask      = (ADDR_W'(1) << cmd_size) - ADDR_W'(1);
    cmd_total     = (ADDR_W'(cmd_len) + ADDR_W'(1)) << cmd_size;
    cmd_wrap_low  = cmd_addr & ~(cmd_total - ADDR_W'(1));
    cmd_last_byte = (cmd_addr & ~cmd_mask) + (ADDR_W'(cmd_len) << cmd_size) + cmd_mask;
    cmd_err       = 1'b1;
    cmd_err_code  = 2'd0;
    if (cmd_burst == B_RSVD) begin
      cmd_err_code = 2'd0;
    end else if (int'(cmd_size) > LANE_W) begin
      cmd_err_code = 2'd1;
    end else if ((cmd_burst == B_WRAP) &&
                 (!(cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15}) || (|(cmd_addr & cmd_mask)))) begin
      cmd_err_code = 2'd2;
    end else if ((cmd_burst == B_INCR) && (|((cmd_last_byte ^ cmd_addr) >> 12))) begin
      cmd_err_code = 2'd3;
    end else begin
      cmd_err = 1'b0;
    end
  end

  // Address of the following beat for the active burst type
  always_comb begin
    step     = ADDR_W'(1) << size_q;
    wrap_inc = addr_q + step;
    case (burst_q)
      B_INCR:  addr_nxt = (addr_q & ~(step - ADDR_W'(1))) + step;
      B_WRAP:  addr_nxt = (wrap_inc == wrap_end_q) ? wrap_low_q : wrap_inc;
      default: addr_nxt = addr_q;
    endcase
  end

  // FSM outputs; cmd_ready opens on the last-beat handshake for bubble-free chaining
  always_comb begin
    beat_valid = (state_q == S_BURST);
    beat_last  = beat_valid && (idx_q == len_q);
    cmd_ready  = (state_q == S_IDLE) || (beat_valid && beat_ready && beat_last);
    cmd_acc    = cmd_valid && cmd_ready;
    beat_acc   = beat_valid && beat_ready;
  end

  // FSM next state: a legal command starts or continues a burst, an illegal one idles
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc && !cmd_err) state_d = S_BURST;
      end
      S_BURST: begin
        if (beat_acc && beat_last) state_d = (cmd_acc && !cmd_err) ? S_BURST : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Command capture, beat advance and error reporting
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_q      <= '0;
      wrap_low_q  <= '0;
      wrap_end_q  <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= B_FIXED;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'd0;
    end else begin
      err_valid_q <= 1'b0;
      if (cmd_acc) begin
        if (cmd_err) begin
          err_valid_q <= 1'b1;
          err_code_q  <= cmd_err_code;
        end else begin
          addr_q     <= cmd_addr;
          idx_q      <= 8'd0;
          len_q      <= cmd_len;
          size_q     <= cmd_size;
          burst_q    <= cmd_burst;
          wrap_low_q <= cmd_wrap_low;
          wrap_end_q <= cmd_wrap_low + cmd_total;
        end
      end else if (beat_acc && !beat_last) begin
        addr_q <= addr_nxt;
        idx_q  <= idx_q + 8'd1;
      end
    end
  end

  assign beat_addr = addr_q;
  assign beat_lane = addr_q[LANE_W-1:0];
  assign beat_idx  = idx_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_ladybird_axi_burst_addr_gen.sv
// Directed bench for the burst address generator (ADDR_W=32, DATA_W=32).
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
// Expected values are hand-computed per test step.
module tb_ladybird_axi_burst_addr_gen;

  logic        clk = 1'b0;
  logic        nrst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        beat_valid;
  logic        beat_ready;
  logic [31:0] beat_addr;
  logic [1:0]  beat_lane;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic        err_valid;
  logic [1:0]  err_code;

  int errors = 0;
  int checks = 0;

  ladybird_axi_burst_addr_gen #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .nrst(nrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .beat_valid(beat_valid), .beat_ready(beat_ready),
    .beat_addr(beat_addr), .beat_lane(beat_lane), .beat_idx(beat_idx), .beat_last(beat_last),
    .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] a, input logic [7:0] i, input logic l);
    chk({tag, ".valid"}, 64'(beat_valid), 64'd1);
    chk({tag, ".addr"},  64'(beat_addr),  64'(a));
    chk({tag, ".idx"},   64'(beat_idx),   64'(i));
    chk({tag, ".last"},  64'(beat_last),  64'(l));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command, check it is accepted on the coming edge, then drop valid
  task automatic issue(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b; cmd_valid = 1'b1;
    #1;
    chk("cmd_ready_at_issue", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic chk_err(input string tag, input logic [1:0] code);
    chk({tag, ".err_valid"},  64'(err_valid),  64'd1);
    chk({tag, ".err_code"},   64'(err_code),   64'(code));
    chk({tag, ".beat_valid"}, 64'(beat_valid), 64'd0);
    tick();
    chk({tag, ".err_drop"},   64'(err_valid),  64'd0);
    chk({tag, ".code_hold"},  64'(err_code),   64'(code));
  endtask

  initial begin
    nrst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
    cmd_burst = '0; beat_ready = 1'b1;
    #12;
    chk("rst.beat_valid", 64'(beat_valid), 64'd0);
    chk("rst.cmd_ready",  64'(cmd_ready),  64'd1);
    chk("rst.beat_addr",  64'(beat_addr),  64'd0);
    chk("rst.beat_idx",   64'(beat_idx),   64'd0);
    chk("rst.beat_last",  64'(beat_last),  64'd0);
    chk("rst.err_valid",  64'(err_valid),  64'd0);
    chk("rst.err_code",   64'(err_code),   64'd0);
    nrst = 1'b1;
    tick();

    // INCR 0x1004 size 2 len 3
    issue(32'h1004, 8'd3, 3'd2, 2'd1);
    chk_beat("incr0", 32'h1004, 8'd0, 1'b0);
    tick(); chk_beat("incr1", 32'h1008, 8'd1, 1'b0);
    tick(); chk_beat("incr2", 32'h100C, 8'd2, 1'b0);
    tick(); chk_beat("incr3", 32'h1010, 8'd3, 1'b1);
    tick(); chk("incr.end_valid", 64'(beat_valid), 64'd0);

    // INCR unaligned 0x1002 size 2 len 2
    issue(32'h1002, 8'd2, 3'd2, 2'd1);
    chk_beat("unal0", 32'h1002, 8'd0, 1'b0); chk("unal0.lane", 64'(beat_lane), 64'd2);
    tick(); chk_beat("unal1", 32'h1004, 8'd1, 1'b0); chk("unal1.lane", 64'(beat_lane), 64'd0);
    tick(); chk_beat("unal2", 32'h1008, 8'd2, 1'b1); chk("unal2.lane", 64'(beat_lane), 64'd0);
    tick(); chk("unal.end_valid", 64'(beat_valid), 64'd0);

    // WRAP 0x8 size 2 len 3 (window 0x0..0xF)
    issue(32'h0008, 8'd3, 3'd2, 2'd2);
    chk_beat("wrap0", 32'h8, 8'd0, 1'b0);
    tick(); chk_beat("wrap1", 32'hC, 8'd1, 1'b0);
    tick(); chk_beat("wrap2", 32'h0, 8'd2, 1'b0);
    tick(); chk_beat("wrap3", 32'h4, 8'd3, 1'b1);
    tick(); chk("wrap.end_valid", 64'(beat_valid), 64'd0);
    issue(32'h0008, 8'd2, 3'd2, 2'd2);
    chk_err("wrap_len2", 2'd2);

    // FIXED 0x40 with beat_ready toggling
    issue(32'h0040, 8'd2, 3'd2, 2'd0);
    beat_ready = 1'b1; #1; chk_beat("fix0", 32'h40, 8'd0, 1'b0);
    tick(); beat_ready = 1'b0; chk_beat("fix1", 32'h40, 8'd1, 1'b0);
    cmd_valid = 1'b1; cmd_burst = 2'd1; #1;
    chk("fix.stall_cmd_ready", 64'(cmd_ready), 64'd0);
    tick(); cmd_valid = 1'b0; chk_beat("fix1_hold", 32'h40, 8'd1, 1'b0);
    beat_ready = 1'b1;
    tick(); beat_ready = 1'b0; chk_beat("fix2", 32'h40, 8'd2, 1'b1);
    tick(); chk_beat("fix2_hold", 32'h40, 8'd2, 1'b1);
    beat_ready = 1'b1;
    tick(); chk("fix.end_valid", 64'(beat_valid), 64'd0);

    // Illegal commands
    issue(32'h0FF8, 8'd3, 3'd2, 2'd1);
    chk_err("page_cross", 2'd3);
    issue(32'h0000, 8'd0, 3'd3, 2'd1);
    chk_err("size_big", 2'd1);
    issue(32'h0000, 8'd0, 3'd2, 2'd3);
    chk_err("burst_rsvd", 2'd0);

    // Back-to-back INCR with cmd_valid held
    issue(32'h2000, 8'd1, 3'd2, 2'd1);
    cmd_valid = 1'b1; cmd_addr = 32'h3000; #1;
    chk_beat("b2b_a0", 32'h2000, 8'd0, 1'b0);
    chk("b2b.holdoff", 64'(cmd_ready), 64'd0);
    tick(); chk_beat("b2b_a1", 32'h2004, 8'd1, 1'b1);
    chk("b2b.ready_on_last", 64'(cmd_ready), 64'd1);
    tick(); cmd_valid = 1'b0;
    chk_beat("b2b_b0", 32'h3000, 8'd0, 1'b0);
    tick(); chk_beat("b2b_b1", 32'h3004, 8'd1, 1'b1);
    tick(); chk("b2b.end_valid", 64'(beat_valid), 64'd0);

    // Third burst aborted by reset on beat 2
    issue(32'h4000, 8'd3, 3'd2, 2'd1);
    chk_beat("abort0", 32'h4000, 8'd0, 1'b0);
    tick(); chk_beat("abort1", 32'h4004, 8'd1, 1'b0);
    tick(); chk_beat("abort2", 32'h4008, 8'd2, 1'b0);
    nrst = 1'b0; #1;
    chk("abort.beat_valid", 64'(beat_valid), 64'd0);
    chk("abort.cmd_ready",  64'(cmd_ready),  64'd1);
    chk("abort.beat_idx",   64'(beat_idx),   64'd0);
    chk("abort.beat_addr",  64'(beat_addr),  64'd0);
    tick(); nrst = 1'b1;
    tick();

    // Single-beat burst after reset
    issue(32'h0080, 8'd0, 3'd2, 2'd0);
    chk_beat("len0", 32'h80, 8'd0, 1'b1);
    tick(); chk("len0.end_valid", 64'(beat_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #20000;
    $display("FAIL timeout: sequence did not complete");
    $fatal(1, "timeout");
  end

endmodule
